// File: rtl/magnitude_peak_detect.sv
// Per-frame peak finder on the magnitude stream: reports max, its bin and a threshold flag.
// Optional frame-sum output is enabled by defining MAG_PEAK_SUM_EN.
module magnitude_peak_detect #(
    parameter int DATA_IN_BITS = 17,
    parameter int FRAME_LEN    = 256,
    parameter int INDEX_BITS   = $clog2(FRAME_LEN),
    parameter int SUM_BITS     = DATA_IN_BITS + INDEX_BITS
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_IN_BITS-1:0] data_in,
    input  logic                    data_in_ready,
    input  logic                    frame_start,
    input  logic [DATA_IN_BITS-1:0] threshold,
    output logic [DATA_IN_BITS-1:0] peak_out,
    output logic [INDEX_BITS-1:0]   peak_index,
    output logic                    peak_detect,
    output logic                    peak_out_ready,
    output logic                    frame_error
`ifdef MAG_PEAK_SUM_EN
    ,
    output logic [SUM_BITS-1:0]     sum_out
`endif
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    localparam logic [INDEX_BITS-1:0] LAST_BIN = INDEX_BITS'(FRAME_LEN - 1);

    state_t                  state_reg;
    logic [INDEX_BITS-1:0]   count_reg;
    logic [DATA_IN_BITS-1:0] max_reg;
    logic [INDEX_BITS-1:0]   idx_reg;
    logic [DATA_IN_BITS-1:0] thr_reg;
    logic [DATA_IN_BITS-1:0] max_next;
    logic [INDEX_BITS-1:0]   idx_next;
    logic                    last_bin;
`ifdef MAG_PEAK_SUM_EN
    logic [SUM_BITS-1:0]     sum_reg;
    logic [SUM_BITS-1:0]     sum_next;
`endif

    // Strict compare keeps the earliest bin on ties.
    always_comb begin
        max_next = max_reg;
        idx_next = idx_reg;
        if (data_in > max_reg) begin
            max_next = data_in;
            idx_next = count_reg;
        end
        last_bin = (count_reg == LAST_BIN);
`ifdef MAG_PEAK_SUM_EN
        sum_next = sum_reg + SUM_BITS'(data_in);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            count_reg      <= '0;
            max_reg        <= '0;
            idx_reg        <= '0;
            thr_reg        <= '0;
            peak_out       <= '0;
            peak_index     <= '0;
            peak_detect    <= 1'b0;
            peak_out_ready <= 1'b0;
            frame_error    <= 1'b0;
`ifdef MAG_PEAK_SUM_EN
            sum_reg        <= '0;
            sum_out        <= '0;
`endif
        end else begin
            peak_out_ready <= 1'b0;
            frame_error    <= 1'b0;
            if (data_in_ready) begin
                if (frame_start) begin
                    // Bin 0 of a new frame; any frame in progress is abandoned.
                    if (state_reg == ACTIVE) begin
                        frame_error <= 1'b1;
                    end
                    state_reg <= ACTIVE;
                    max_reg   <= data_in;
                    idx_reg   <= '0;
                    count_reg <= INDEX_BITS'(1);
                    thr_reg   <= threshold;
`ifdef MAG_PEAK_SUM_EN
                    sum_reg   <= SUM_BITS'(data_in);
`endif
                end else if (state_reg == ACTIVE) begin
                    max_reg <= max_next;
                    idx_reg <= idx_next;
`ifdef MAG_PEAK_SUM_EN
                    sum_reg <= sum_next;
`endif
                    if (last_bin) begin
                        state_reg      <= IDLE;
                        count_reg      <= '0;
                        peak_out       <= max_next;
                        peak_index     <= idx_next;
                        peak_detect    <= (max_next > thr_reg);
                        peak_out_ready <= 1'b1;
`ifdef MAG_PEAK_SUM_EN
                        sum_out        <= sum_next;
`endif
                    end else begin
                        count_reg <= count_reg + INDEX_BITS'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_magnitude_peak_detect.sv
// Directed bench for magnitude_peak_detect with FRAME_LEN=8: vector table plus corner sequences.
module tb_magnitude_peak_detect;

    localparam int DW = 17;
    localparam int FL = 8;
    localparam int IW = 3;
    localparam int SW = 20;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          data_in_ready = 1'b0;
    logic          frame_start = 1'b0;
    logic [DW-1:0] threshold = '0;
    logic [DW-1:0] peak_out;
    logic [IW-1:0] peak_index;
    logic          peak_detect;
    logic          peak_out_ready;
    logic          frame_error;
`ifdef MAG_PEAK_SUM_EN
    logic [SW-1:0] sum_out;
`endif

    always #5 clk = ~clk;

    magnitude_peak_detect #(
        .DATA_IN_BITS(DW),
        .FRAME_LEN(FL)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .data_in(data_in),
        .data_in_ready(data_in_ready),
        .frame_start(frame_start),
        .threshold(threshold),
        .peak_out(peak_out),
        .peak_index(peak_index),
        .peak_detect(peak_detect),
        .peak_out_ready(peak_out_ready),
        .frame_error(frame_error)
`ifdef MAG_PEAK_SUM_EN
        ,
        .sum_out(sum_out)
`endif
    );

    typedef struct {
        logic [FL-1:0][DW-1:0] s;
        logic [DW-1:0]         thr;
        logic [DW-1:0]         pk;
        logic [IW-1:0]         idx;
        logic                  det;
        logic [SW-1:0]         sum;
    } vec_t;

    localparam int NV = 6;
    vec_t vt [NV];

    int tests = 0;
    int fails = 0;
    int rdy_cnt = 0;
    int err_cnt = 0;

    // Pulse monitor on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (peak_out_ready) rdy_cnt++;
            if (frame_error) err_cnt++;
            if (peak_out_ready && frame_error) begin
                tests++;
                fails++;
                $display("FAIL pulse_overlap: ready=%0b error=%0b required not both high", peak_out_ready, frame_error);
            end
        end
    end

    task automatic check(input string nm, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d required %0d", nm, act, exp);
        end
    endtask

    task automatic set_vec(input int i, input int b0, input int b1, input int b2, input int b3,
                           input int b4, input int b5, input int b6, input int b7,
                           input int thr, input int pk, input int idx, input int det, input int sum);
        vt[i].s[0] = DW'(b0); vt[i].s[1] = DW'(b1); vt[i].s[2] = DW'(b2); vt[i].s[3] = DW'(b3);
        vt[i].s[4] = DW'(b4); vt[i].s[5] = DW'(b5); vt[i].s[6] = DW'(b6); vt[i].s[7] = DW'(b7);
        vt[i].thr = DW'(thr);
        vt[i].pk  = DW'(pk);
        vt[i].idx = IW'(idx);
        vt[i].det = det[0];
        vt[i].sum = SW'(sum);
    endtask

    // One strobe after `gap` idle cycles; returns 1 time unit after the accepting edge.
    task automatic send(input logic [DW-1:0] v, input logic fs, input int gap);
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        data_in = v;
        data_in_ready = 1'b1;
        frame_start = fs;
        @(posedge clk);
        #1;
        data_in_ready = 1'b0;
        frame_start = 1'b0;
        data_in = '0;
    endtask

    task automatic check_result(input string nm, input int i);
        check({nm, "_ready"}, peak_out_ready, 1);
        check({nm, "_peak"}, peak_out, vt[i].pk);
        check({nm, "_index"}, peak_index, vt[i].idx);
        check({nm, "_detect"}, peak_detect, vt[i].det);
`ifdef MAG_PEAK_SUM_EN
        check({nm, "_sum"}, sum_out, vt[i].sum);
`endif
    endtask

    task automatic run_frame(input int i, input int gap_seed);
        int r0;
        int e0;
        r0 = rdy_cnt;
        e0 = err_cnt;
        threshold = vt[i].thr;
        for (int b = 0; b < FL; b++) begin
            send(vt[i].s[b], (b == 0), (b + gap_seed) % 4);
        end
        check_result($sformatf("vec%0d", i), i);
        @(posedge clk);
        #1;
        check($sformatf("vec%0d_pulse_width", i), peak_out_ready, 0);
        check($sformatf("vec%0d_pulse_count", i), rdy_cnt - r0, 1);
        check($sformatf("vec%0d_no_error", i), err_cnt - e0, 0);
        $display("[TB] frame vec%0d peak=%0d index=%0d detect=%0b", i, peak_out, peak_index, peak_detect);
    endtask

    initial begin
        int r0;
        int e0;
        set_vec(0, 3, 9, 2, 9, 1, 0, 5, 4, 8, 9, 1, 1, 33);
        set_vec(1, 3, 9, 2, 9, 1, 0, 5, 4, 9, 9, 1, 0, 33);
        set_vec(2, 7, 7, 7, 7, 7, 7, 7, 7, 0, 7, 0, 1, 56);
        set_vec(3, 0, 1, 2, 3, 4, 5, 6, 7, 7, 7, 7, 0, 28);
        set_vec(4, 131070, 131070, 131070, 131070, 131070, 131070, 131070, 131071,
                131070, 131071, 7, 1, 1048561);
        set_vec(5, 5, 5, 5, 5, 5, 5, 5, 5, 5, 5, 0, 0, 40);

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("reset_peak", peak_out, 0);
        check("reset_index", peak_index, 0);
        check("reset_detect", peak_detect, 0);
        check("reset_ready", peak_out_ready, 0);
        check("reset_error", frame_error, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Strobes with no frame_start are ignored while idle.
        for (int k = 0; k < 3; k++) send(DW'(100 + k), 1'b0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("prestart_no_pulse", rdy_cnt + err_cnt, 0);
        check("prestart_peak", peak_out, 0);
        $display("[TB] prestart strobes ignored");

        for (int i = 0; i < NV; i++) run_frame(i, i);

        // Output holds after the pulse.
        repeat (5) @(posedge clk);
        #1;
        check("hold_peak", peak_out, vt[NV-1].pk);

        // Early frame_start at bin 5 aborts; that sample becomes bin 0 of a frame of 7s.
        r0 = rdy_cnt;
        e0 = err_cnt;
        threshold = 3;
        for (int b = 0; b < 5; b++) send(DW'(50 + b), (b == 0), 0);
        send(DW'(7), 1'b1, 0);
        check("early_error_pulse", frame_error, 1);
        check("early_no_ready", peak_out_ready, 0);
        threshold = 0;
        for (int b = 1; b < FL; b++) send(DW'(7), 1'b0, 1);
        check_result("early_new", 2);
        @(posedge clk);
        #1;
        check("early_ready_count", rdy_cnt - r0, 1);
        check("early_error_count", err_cnt - e0, 1);
        $display("[TB] early restart at bin5 peak=%0d index=%0d", peak_out, peak_index);

        // frame_start on the last bin is also an abort, not a completion.
        r0 = rdy_cnt;
        e0 = err_cnt;
        threshold = vt[3].thr;
        for (int b = 0; b < FL - 1; b++) send(DW'(20), (b == 0), 0);
        send(vt[3].s[0], 1'b1, 0);
        check("lastbin_error", frame_error, 1);
        check("lastbin_no_ready", peak_out_ready, 0);
        for (int b = 1; b < FL; b++) send(vt[3].s[b], 1'b0, 0);
        check_result("lastbin_new", 3);
        @(posedge clk);
        #1;
        check("lastbin_ready_count", rdy_cnt - r0, 1);
        check("lastbin_error_count", err_cnt - e0, 1);
        $display("[TB] restart on last bin peak=%0d index=%0d", peak_out, peak_index);

        // Back-to-back frames: two pulses exactly 8 strobes apart, no error.
        r0 = rdy_cnt;
        e0 = err_cnt;
        for (int f = 0; f < 2; f++) begin
            threshold = vt[f].thr;
            for (int b = 0; b < FL; b++) send(vt[f].s[b], (b == 0), 0);
            check_result($sformatf("b2b%0d", f), f);
        end
        @(posedge clk);
        #1;
        check("b2b_ready_count", rdy_cnt - r0, 2);
        check("b2b_error_count", err_cnt - e0, 0);
        $display("[TB] back-to-back frames done");

        // Reset asserted at bin 4 clears everything with no pulse.
        r0 = rdy_cnt;
        e0 = err_cnt;
        threshold = 0;
        for (int b = 0; b < 4; b++) send(DW'(90), (b == 0), 0);
        rst_n = 1'b0;
        #1;
        check("midrst_peak", peak_out, 0);
        check("midrst_index", peak_index, 0);
        check("midrst_detect", peak_detect, 0);
        check("midrst_ready", peak_out_ready, 0);
        check("midrst_error", frame_error, 0);
        for (int b = 4; b < FL; b++) begin
            data_in = DW'(90);
            data_in_ready = 1'b1;
            @(posedge clk);
            #1;
        end
        data_in_ready = 1'b0;
        check("midrst_no_pulse", (rdy_cnt - r0) + (err_cnt - e0), 0);
        check("midrst_peak_held0", peak_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_frame(0, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: sim time exceeded limit, required finish");
        $fatal(1);
    end

endmodule
